// File: rtl/logo_sprite_drawer.sv
// -----------------------------------------------------------------------------
// logo_sprite_drawer
//
// Pixel-pipeline stage between the VGA sync counter and the logo ROM. It turns
// the current DrawX/DrawY into a ROM read address for a LOGO_W x LOGO_H sprite
// and keys out the transparent colour. The result is muxed over the supplied
// background colour. The sprite bounces around the visible screen, moving one
// step per frame.
//
// Pipeline (2 cycles DrawX/DrawY -> pixel_out, one pixel per clock):
//   stage 1: hit test, ROM address, delay of video_on/bg_color
//   stage 2: colour key / background mux, blanking
//
// Ports:
//   Clk          pixel clock, all state on rising edge
//   Reset        asynchronous active-high reset
//   DrawX/DrawY  current pixel column/row
//   video_on     high during the visible region
//   frame_start  one-cycle pulse per frame (vertical blanking)
//   move_en      low freezes the sprite position
//   bg_color     background RGB444 for the current pixel
//   rom_address  read address to the logo ROM (registered)
//   rom_color    combinational ROM data for rom_address
//   pixel_out    final RGB444 pixel
//   pixel_valid  pixel_out belongs to a visible pixel
//   logo_x/y     current sprite origin
//
// Optional feature macro: LOGO_MIRROR_EN
//   When defined, the sprite is mirrored horizontally while it travels left.
// -----------------------------------------------------------------------------
module logo_sprite_drawer #(
  parameter int          LOGO_W    = 256,
  parameter int          LOGO_H    = 242,
  parameter int          H_RES     = 640,
  parameter int          V_RES     = 480,
  parameter int          INIT_X    = 192,
  parameter int          INIT_Y    = 119,
  parameter int          STEP      = 2,
  parameter logic [11:0] KEY_COLOR = 12'h808
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        video_on,
  input  logic        frame_start,
  input  logic        move_en,
  input  logic [11:0] bg_color,
  output logic [15:0] rom_address,
  input  logic [11:0] rom_color,
  output logic [11:0] pixel_out,
  output logic        pixel_valid,
  output logic [9:0]  logo_x,
  output logic [9:0]  logo_y
);

  typedef enum logic {FWD = 1'b0, REV = 1'b1} dir_t;

  // Stage 1 registers
  logic [15:0] rom_address_q, rom_address_d;
  logic        hit_q, hit_d;
  logic        video_on_q, video_on_d;
  logic [11:0] bg_color_q, bg_color_d;

  // Stage 2 registers
  logic [11:0] pixel_out_q, pixel_out_d;
  logic        pixel_valid_q, pixel_valid_d;

  // Motion state
  logic [9:0]  logo_x_q, logo_x_d;
  logic [9:0]  logo_y_q, logo_y_d;
  dir_t        dir_x_q, dir_x_d;
  dir_t        dir_y_q, dir_y_d;

  // Stage 1 working values; 11-bit so origin + size never wraps
  logic [10:0] draw_x_w, draw_y_w;
  logic [10:0] logo_x_w, logo_y_w;
  logic [10:0] logo_x_end, logo_y_end;
  logic [9:0]  rel_x, rel_y;
  logic [15:0] rel_x16, rel_y16, col16;

  // Motion working values
  logic [10:0] x_fwd_end, y_fwd_end;

  // Stage 1: hit test and ROM address generation
  always_comb begin
    draw_x_w   = {1'b0, DrawX};
    draw_y_w   = {1'b0, DrawY};
    logo_x_w   = {1'b0, logo_x_q};
    logo_y_w   = {1'b0, logo_y_q};
    logo_x_end = logo_x_w + 11'(LOGO_W);
    logo_y_end = logo_y_w + 11'(LOGO_H);

    hit_d = video_on &&
            (draw_x_w >= logo_x_w) && (draw_x_w < logo_x_end) &&
            (draw_y_w >= logo_y_w) && (draw_y_w < logo_y_end);

    rel_x   = DrawX - logo_x_q;
    rel_y   = DrawY - logo_y_q;
    rel_x16 = 16'(rel_x);
    rel_y16 = 16'(rel_y);

`ifdef LOGO_MIRROR_EN
    // Travelling left: read the row back to front so the logo faces its motion
    if (dir_x_q == REV) begin
      col16 = 16'(LOGO_W - 1) - rel_x16;
    end else begin
      col16 = rel_x16;
    end
`else
    col16 = rel_x16;
`endif

    rom_address_d = hit_d ? 16'(rel_y16 * 16'(LOGO_W) + col16) : 16'h0000;
    video_on_d    = video_on;
    bg_color_d    = bg_color;
  end

  // Stage 2: colour key, background mux and blanking
  always_comb begin
    pixel_valid_d = video_on_q;
    if (!video_on_q) begin
      pixel_out_d = 12'h000;
    end else if (hit_q && (rom_color != KEY_COLOR)) begin
      pixel_out_d = rom_color;
    end else begin
      pixel_out_d = bg_color_q;
    end
  end

  // Motion: each axis bounces independently, one step per enabled frame.
  // On hitting an edge the sprite is clamped to it and reverses.
  always_comb begin
    logo_x_d  = logo_x_q;
    logo_y_d  = logo_y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    x_fwd_end = {1'b0, logo_x_q} + 11'(STEP) + 11'(LOGO_W);
    y_fwd_end = {1'b0, logo_y_q} + 11'(STEP) + 11'(LOGO_H);

    if (frame_start && move_en) begin
      if (dir_x_q == FWD) begin
        if (x_fwd_end > 11'(H_RES)) begin
          dir_x_d  = REV;
          logo_x_d = 10'(H_RES - LOGO_W);
        end else begin
          logo_x_d = logo_x_q + 10'(STEP);
        end
      end else begin
        if (logo_x_q < 10'(STEP)) begin
          dir_x_d  = FWD;
          logo_x_d = 10'd0;
        end else begin
          logo_x_d = logo_x_q - 10'(STEP);
        end
      end

      if (dir_y_q == FWD) begin
        if (y_fwd_end > 11'(V_RES)) begin
          dir_y_d  = REV;
          logo_y_d = 10'(V_RES - LOGO_H);
        end else begin
          logo_y_d = logo_y_q + 10'(STEP);
        end
      end else begin
        if (logo_y_q < 10'(STEP)) begin
          dir_y_d  = FWD;
          logo_y_d = 10'd0;
        end else begin
          logo_y_d = logo_y_q - 10'(STEP);
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_address_q <= 16'h0000;
      hit_q         <= 1'b0;
      video_on_q    <= 1'b0;
      bg_color_q    <= 12'h000;
      pixel_out_q   <= 12'h000;
      pixel_valid_q <= 1'b0;
      logo_x_q      <= 10'(INIT_X);
      logo_y_q      <= 10'(INIT_Y);
      dir_x_q       <= FWD;
      dir_y_q       <= FWD;
    end else begin
      rom_address_q <= rom_address_d;
      hit_q         <= hit_d;
      video_on_q    <= video_on_d;
      bg_color_q    <= bg_color_d;
      pixel_out_q   <= pixel_out_d;
      pixel_valid_q <= pixel_valid_d;
      logo_x_q      <= logo_x_d;
      logo_y_q      <= logo_y_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
    end
  end

  assign rom_address = rom_address_q;
  assign pixel_out   = pixel_out_q;
  assign pixel_valid = pixel_valid_q;
  assign logo_x      = logo_x_q;
  assign logo_y      = logo_y_q;

endmodule

// File: tb/tb_logo_sprite_drawer.sv
// -----------------------------------------------------------------------------
// tb_logo_sprite_drawer
//
// Self-checking bench for logo_sprite_drawer. A table of pixel vectors checks
// addressing, colour keying and blanking at the reset position. Hand-written
// sequences cover the bounce motion, move_en freeze, mirroring, and reset
// applied mid-stream.
// -----------------------------------------------------------------------------
module tb_logo_sprite_drawer;

  logic        clk;
  logic        rst;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic        video_on;
  logic        frame_start;
  logic        move_en;
  logic [11:0] bg_color;
  logic [15:0] rom_address;
  logic [11:0] rom_color;
  logic [11:0] pixel_out;
  logic        pixel_valid;
  logic [9:0]  logo_x;
  logic [9:0]  logo_y;

  int checks;
  int failures;

  logo_sprite_drawer dut (
    .Clk         (clk),
    .Reset       (rst),
    .DrawX       (draw_x),
    .DrawY       (draw_y),
    .video_on    (video_on),
    .frame_start (frame_start),
    .move_en     (move_en),
    .bg_color    (bg_color),
    .rom_address (rom_address),
    .rom_color   (rom_color),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .logo_x      (logo_x),
    .logo_y      (logo_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic        vo;
    logic [11:0] bg;
    logic [11:0] rc;
    logic [15:0] exp_addr;
    logic [11:0] exp_pix;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[11];

  // Advance one clock; returns 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] dx, input logic [9:0] dy,
                               input logic vo, input logic [11:0] bg,
                               input logic [11:0] rc);
    draw_x   = dx;
    draw_y   = dy;
    video_on = vo;
    bg_color = bg;
    rom_color = rc;
  endtask

  task automatic pulseFrame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_mirror;
    checks   = 0;
    failures = 0;

    //          name           dx   dy  vo  bg       rc       addr   pix      valid
    vecs[0]  = '{"origin",     192, 119, 1, 12'h000, 12'h0AE, 16'd0,     12'h0AE, 1'b1};
    vecs[1]  = '{"bot_right",  447, 360, 1, 12'h111, 12'h5A5, 16'd61951, 12'h5A5, 1'b1};
    vecs[2]  = '{"right_out",  448, 200, 1, 12'h123, 12'h0AE, 16'd0,     12'h123, 1'b1};
    vecs[3]  = '{"key_color",  300, 200, 1, 12'h456, 12'h808, 16'd20844, 12'h456, 1'b1};
    vecs[4]  = '{"blanked",    300, 200, 0, 12'h456, 12'h0AE, 16'd0,     12'h000, 1'b0};
    vecs[5]  = '{"left_out",   191, 119, 1, 12'h222, 12'h0AE, 16'd0,     12'h222, 1'b1};
    vecs[6]  = '{"top_out",    192, 118, 1, 12'h333, 12'h0AE, 16'd0,     12'h333, 1'b1};
    vecs[7]  = '{"bottom_out", 192, 361, 1, 12'h444, 12'h0AE, 16'd0,     12'h444, 1'b1};
    vecs[8]  = '{"inner",      200, 120, 1, 12'h000, 12'hFFF, 16'd264,   12'hFFF, 1'b1};
    vecs[9]  = '{"corner_out", 639, 479, 1, 12'h7E7, 12'h0AE, 16'd0,     12'h7E7, 1'b1};
    vecs[10] = '{"near_key",   193, 119, 1, 12'h456, 12'h809, 16'd1,     12'h809, 1'b1};

    // Reset state
    rst = 1'b1;
    move_en = 1'b0;
    frame_start = 1'b0;
    applyStimulus(10'd0, 10'd0, 1'b0, 12'h000, 12'h000);
    #2;
    checkOutput("rst_addr",  rom_address, 16'd0);
    checkOutput("rst_pix",   16'(pixel_out), 16'h000);
    checkOutput("rst_valid", 16'(pixel_valid), 16'd0);
    checkOutput("rst_x",     16'(logo_x), 16'd192);
    checkOutput("rst_y",     16'(logo_y), 16'd119);
    tick();
    tick();
    rst = 1'b0;

    // Table-driven pixel vectors at the reset position
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].dx, vecs[i].dy, vecs[i].vo, vecs[i].bg, 12'h000);
      tick();
      checkOutput({vecs[i].name, "_addr"}, rom_address, vecs[i].exp_addr);
      rom_color = vecs[i].rc;
      tick();
      checkOutput({vecs[i].name, "_pix"}, 16'(pixel_out), 16'(vecs[i].exp_pix));
      checkOutput({vecs[i].name, "_valid"}, 16'(pixel_valid), 16'(vecs[i].exp_valid));
    end

    // Motion: bounce off the right and bottom edges
    applyStimulus(10'd0, 10'd0, 1'b0, 12'h000, 12'h000);
    move_en = 1'b1;
    for (int p = 1; p <= 98; p++) begin
      pulseFrame();
      if (p == 1) begin
        checkOutput("move1_x", 16'(logo_x), 16'd194);
        checkOutput("move1_y", 16'(logo_y), 16'd121);
      end
      if (p == 59) checkOutput("move59_y", 16'(logo_y), 16'd237);
      if (p == 60) checkOutput("move60_y", 16'(logo_y), 16'd238);
      if (p == 61) checkOutput("move61_y", 16'(logo_y), 16'd236);
      if (p == 96) checkOutput("move96_x", 16'(logo_x), 16'd384);
      if (p == 97) checkOutput("move97_x", 16'(logo_x), 16'd384);
      if (p == 98) begin
        checkOutput("move98_x", 16'(logo_x), 16'd382);
        checkOutput("move98_y", 16'(logo_y), 16'd162);
      end
    end

    // move_en low freezes position
    move_en = 1'b0;
    for (int p = 0; p < 10; p++) pulseFrame();
    checkOutput("frozen_x", 16'(logo_x), 16'd382);
    checkOutput("frozen_y", 16'(logo_y), 16'd162);

    // Sprite origin while travelling left: mirrored only with the feature on
`ifdef LOGO_MIRROR_EN
    exp_mirror = 16'd255;
`else
    exp_mirror = 16'd0;
`endif
    applyStimulus(10'd382, 10'd162, 1'b1, 12'h000, 12'h000);
    tick();
    checkOutput("rev_origin_addr", rom_address, exp_mirror);

    // Load a visible non-zero pixel, then reset mid-stream
    applyStimulus(10'd392, 10'd170, 1'b1, 12'h000, 12'h0AE);
    tick();
    tick();
    checkOutput("pre_rst_pix", 16'(pixel_out), 16'h0AE);
    rst = 1'b1;
    #1;
    checkOutput("midrst_pix",   16'(pixel_out), 16'h000);
    checkOutput("midrst_valid", 16'(pixel_valid), 16'd0);
    checkOutput("midrst_addr",  rom_address, 16'd0);
    checkOutput("midrst_x",     16'(logo_x), 16'd192);
    checkOutput("midrst_y",     16'(logo_y), 16'd119);
    tick();
    checkOutput("hold_rst_pix", 16'(pixel_out), 16'h000);
    rst = 1'b0;

    // First pixel after reset release arrives 2 cycles after it is sampled
    applyStimulus(10'd193, 10'd120, 1'b1, 12'h000, 12'h0AE);
    tick();
    checkOutput("post_rst_addr",   rom_address, 16'd257);
    checkOutput("post_rst_valid1", 16'(pixel_valid), 16'd0);
    tick();
    checkOutput("post_rst_valid2", 16'(pixel_valid), 16'd1);
    checkOutput("post_rst_pix",    16'(pixel_out), 16'h0AE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logo_sprite_drawer.md
Name: logo_sprite_drawer

Overview:
Pixel-pipeline stage that sits directly upstream of the logo ROM and downstream of the VGA sync counter.
- Converts the current DrawX/DrawY into a ROM read address for a 256x242 logo sprite.
- Keys out the transparent colour and muxes the result over a background colour.
- Bounces the sprite around the 640x480 screen, one step per frame.
- Its output feeds the VGA RGB output register.

Parameters:
LOGO_W, 256, sprite width in pixels
LOGO_H, 242, sprite height in pixels
H_RES, 640, visible screen width
V_RES, 480, visible screen height
INIT_X, 192, sprite X origin after reset
INIT_Y, 119, sprite Y origin after reset
STEP, 2, pixels moved per frame on each axis
KEY_COLOR, 12'h808, transparent colour code returned by the ROM

Ports:
Clk  input  1  pixel clock; all state on rising edge
Reset  input  1  asynchronous, active-high reset
DrawX  input  10  current pixel column
DrawY  input  10  current pixel row
video_on  input  1  high during the visible region
frame_start  input  1  one-cycle pulse per frame, issued in vertical blanking
move_en  input  1  when low, sprite position is frozen
bg_color  input  12  background RGB444 for the current pixel
rom_address  output  16  read address to the logo ROM
rom_color  input  12  combinational ROM data for rom_address
pixel_out  output  12  final RGB444 pixel
pixel_valid  output  1  pixel_out corresponds to a visible pixel
logo_x  output  10  current sprite X origin
logo_y  output  10  current sprite Y origin

Behaviour:
Reset values (asynchronous):
- rom_address=0, pixel_out=12'h000, pixel_valid=0.
- logo_x=INIT_X, logo_y=INIT_Y.
- dir_x=right, dir_y=down; all pipeline registers cleared.

Stage 1 (registered; captures inputs at edge N):
- hit = video_on && DrawX>=logo_x && DrawX<logo_x+LOGO_W && DrawY>=logo_y && DrawY<logo_y+LOGO_H.
- rel_x=DrawX-logo_x, rel_y=DrawY-logo_y.
- rom_address = hit ? rel_y*LOGO_W+rel_x (16-bit, truncated) : 0.
- Delay hit, video_on and bg_color by one stage alongside.
- Comparisons use 11-bit arithmetic so logo_x+LOGO_W never wraps.

Stage 2 (registered at edge N+1):
- pixel_out = (hit_d && rom_color!=KEY_COLOR) ? rom_color : bg_color_d.
- pixel_valid = video_on_d.
- If video_on_d is low, pixel_out = 12'h000.
- Total latency DrawX/DrawY to pixel_out = 2 cycles, fully pipelined, one pixel per clock.

Motion FSM (per axis, states FWD/REV), evaluated only when frame_start && move_en:
- X in FWD: if logo_x+STEP+LOGO_W > H_RES, go to REV and set logo_x=H_RES-LOGO_W; else logo_x+=STEP.
- X in REV: if logo_x<STEP, go to FWD and set logo_x=0; else logo_x-=STEP.
- Y follows the same rules with V_RES, LOGO_H, logo_y.
- X and Y update in the same cycle, independently.
- frame_start while move_en=0: no change.
- A new position applies to stage-1 comparisons on the cycle after the update. A mid-frame pulse is legal and may tear.

Boundary and reset cases:
- The bottom-right pixel of the sprite gives address LOGO_W*LOGO_H-1 (61951 at defaults).
- Reset asserted mid-frame clears the pipeline immediately: pixel_out=0 while Reset is high.
- After reset deasserts, the first valid pixel_out appears 2 cycles after the first sampled input.

Optional Feature:
LOGO_MIRROR_EN
- Defined: while dir_x=REV, the sprite is mirrored horizontally. Stage 1 uses rel_x' = LOGO_W-1-rel_x, so rom_address = rel_y*LOGO_W + (LOGO_W-1-rel_x). Everything else is unchanged.
- Undefined: addressing never mirrors, and dir_x affects motion only.

Test Plan:
1. Reset, then DrawX=192, DrawY=119, video_on=1, rom_color=12'h0AE -> rom_address=0 after 1 cycle; pixel_out=12'h0AE, pixel_valid=1 after 2 cycles.
2. DrawX=447, DrawY=360 -> rom_address=61951. DrawX=448, bg_color=12'h123 -> rom_address=0, pixel_out=12'h123.
3. In-region pixel with rom_color=12'h808, bg_color=12'h456 -> pixel_out=12'h456. With video_on=0 -> pixel_out=0, pixel_valid=0.
4. move_en=1, 96 frame_start pulses -> logo_x=384. 97th pulse -> logo_x=384, dir_x=REV. 98th pulse -> logo_x=382. Y path: after 59 pulses logo_y=237; the 60th gives logo_y=238 and dir_y=REV.
5. move_en=0 with 10 frame_start pulses -> logo_x/logo_y unchanged. Reset mid-stream after motion -> logo_x=192, logo_y=119, pixel_out=0 at once.
6. LOGO_MIRROR_EN defined, dir_x=REV, DrawX=logo_x, DrawY=logo_y -> rom_address=255. Macro undefined, same stimulus -> rom_address=0.
